// File: rtl/axi_lite_arb2_if.sv
// AXI-lite channel bundle shared by the two fetch/data masters and the
// memory slave port of the 2:1 arbiter. "master" is the side that issues
// AW/W/AR and accepts B/R; "slave" is the side that answers them.
interface axi_lite_arb2_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_arb2.sv
// Two-master to one-slave AXI-lite arbiter. Reads and writes are arbitrated
// by independent FSMs, each with one transaction in flight and its own
// round-robin pointer. After the one-cycle IDLE arbitration step every
// channel is a pure combinational route between the granted master and the
// slave, so no latency is added past arbitration.
module axi_lite_arb2 #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input logic             clk,
  input logic             rst,
  axi_lite_arb2_if.slave  m0,
  axi_lite_arb2_if.slave  m1,
  axi_lite_arb2_if.master s
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2} wr_state_t;

  // grant/last value 0 means m0, 1 means m1; last resets to m1 so m0 wins first
  rd_state_t rd_state_r, rd_state_nxt_s;
  logic      rd_grant_r, rd_grant_nxt_s;
  logic      rd_last_r, rd_last_nxt_s;
  wr_state_t wr_state_r, wr_state_nxt_s;
  logic      wr_grant_r, wr_grant_nxt_s;
  logic      wr_last_r, wr_last_nxt_s;
  logic      aw_done_r, aw_done_nxt_s;
  logic      w_done_r, w_done_nxt_s;

  // channel signals of the currently granted master
  logic rd_arvalid_sel_s, rd_rready_sel_s;
  logic wr_awvalid_sel_s, wr_wvalid_sel_s, wr_bready_sel_s;
  logic aw_fin_s, w_fin_s;

  assign rd_arvalid_sel_s = rd_grant_r ? m1.arvalid : m0.arvalid;
  assign rd_rready_sel_s  = rd_grant_r ? m1.rready  : m0.rready;
  assign wr_awvalid_sel_s = wr_grant_r ? m1.awvalid : m0.awvalid;
  assign wr_wvalid_sel_s  = wr_grant_r ? m1.wvalid  : m0.wvalid;
  assign wr_bready_sel_s  = wr_grant_r ? m1.bready  : m0.bready;

  // Read arbiter state, grant and round-robin pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_r <= R_IDLE;
      rd_grant_r <= 1'b0;
      rd_last_r  <= 1'b1;
    end else begin
      rd_state_r <= rd_state_nxt_s;
      rd_grant_r <= rd_grant_nxt_s;
      rd_last_r  <= rd_last_nxt_s;
    end
  end

  // Read next-state logic and AR/R routing between granted master and slave
  always_comb begin
    rd_state_nxt_s = rd_state_r;
    rd_grant_nxt_s = rd_grant_r;
    rd_last_nxt_s  = rd_last_r;
    s.araddr   = {ADDR_WIDTH{1'b0}};
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    m0.arready = 1'b0;
    m0.rdata   = {DATA_WIDTH{1'b0}};
    m0.rresp   = 2'b00;
    m0.rvalid  = 1'b0;
    m1.arready = 1'b0;
    m1.rdata   = {DATA_WIDTH{1'b0}};
    m1.rresp   = 2'b00;
    m1.rvalid  = 1'b0;
    case (rd_state_r)
      R_IDLE: begin
        if (m0.arvalid || m1.arvalid) begin
          // on contention the master not served last wins
          rd_grant_nxt_s = (m0.arvalid && m1.arvalid) ? ~rd_last_r : m1.arvalid;
          rd_state_nxt_s = R_ADDR;
        end else begin
          rd_state_nxt_s = R_IDLE;
        end
      end
      R_ADDR: begin
        s.araddr  = rd_grant_r ? m1.araddr : m0.araddr;
        s.arvalid = rd_arvalid_sel_s;
        if (rd_grant_r) begin
          m1.arready = s.arready;
        end else begin
          m0.arready = s.arready;
        end
        if (rd_arvalid_sel_s && s.arready) begin
          rd_state_nxt_s = R_DATA;
        end else begin
          rd_state_nxt_s = R_ADDR;
        end
      end
      R_DATA: begin
        s.rready = rd_rready_sel_s;
        if (rd_grant_r) begin
          m1.rdata  = s.rdata;
          m1.rresp  = s.rresp;
          m1.rvalid = s.rvalid;
        end else begin
          m0.rdata  = s.rdata;
          m0.rresp  = s.rresp;
          m0.rvalid = s.rvalid;
        end
        if (s.rvalid && rd_rready_sel_s) begin
          rd_state_nxt_s = R_IDLE;
          rd_last_nxt_s  = rd_grant_r;
        end else begin
          rd_state_nxt_s = R_DATA;
        end
      end
      default: begin
        rd_state_nxt_s = R_IDLE;
      end
    endcase
  end

  // Write arbiter state, grant, pointer and AW/W completion flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_r <= W_IDLE;
      wr_grant_r <= 1'b0;
      wr_last_r  <= 1'b1;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
    end else begin
      wr_state_r <= wr_state_nxt_s;
      wr_grant_r <= wr_grant_nxt_s;
      wr_last_r  <= wr_last_nxt_s;
      aw_done_r  <= aw_done_nxt_s;
      w_done_r   <= w_done_nxt_s;
    end
  end

  // Write next-state logic and AW/W/B routing; a finished AW or W is masked
  always_comb begin
    wr_state_nxt_s = wr_state_r;
    wr_grant_nxt_s = wr_grant_r;
    wr_last_nxt_s  = wr_last_r;
    aw_done_nxt_s  = aw_done_r;
    w_done_nxt_s   = w_done_r;
    aw_fin_s   = 1'b0;
    w_fin_s    = 1'b0;
    s.awaddr   = {ADDR_WIDTH{1'b0}};
    s.awvalid  = 1'b0;
    s.wdata    = {DATA_WIDTH{1'b0}};
    s.wstrb    = {STRB_WIDTH{1'b0}};
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bresp   = 2'b00;
    m0.bvalid  = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bresp   = 2'b00;
    m1.bvalid  = 1'b0;
    case (wr_state_r)
      W_IDLE: begin
        if (m0.awvalid || m1.awvalid) begin
          wr_grant_nxt_s = (m0.awvalid && m1.awvalid) ? ~wr_last_r : m1.awvalid;
          wr_state_nxt_s = W_REQ;
        end else begin
          wr_state_nxt_s = W_IDLE;
        end
      end
      W_REQ: begin
        s.awaddr  = wr_grant_r ? m1.awaddr : m0.awaddr;
        s.awvalid = wr_awvalid_sel_s && !aw_done_r;
        s.wdata   = wr_grant_r ? m1.wdata : m0.wdata;
        s.wstrb   = wr_grant_r ? m1.wstrb : m0.wstrb;
        s.wvalid  = wr_wvalid_sel_s && !w_done_r;
        if (wr_grant_r) begin
          m1.awready = s.awready && !aw_done_r;
          m1.wready  = s.wready && !w_done_r;
        end else begin
          m0.awready = s.awready && !aw_done_r;
          m0.wready  = s.wready && !w_done_r;
        end
        aw_fin_s = aw_done_r || (wr_awvalid_sel_s && s.awready);
        w_fin_s  = w_done_r || (wr_wvalid_sel_s && s.wready);
        if (aw_fin_s && w_fin_s) begin
          wr_state_nxt_s = W_RESP;
          aw_done_nxt_s  = 1'b0;
          w_done_nxt_s   = 1'b0;
        end else begin
          wr_state_nxt_s = W_REQ;
          aw_done_nxt_s  = aw_fin_s;
          w_done_nxt_s   = w_fin_s;
        end
      end
      W_RESP: begin
        s.bready = wr_bready_sel_s;
        if (wr_grant_r) begin
          m1.bresp  = s.bresp;
          m1.bvalid = s.bvalid;
        end else begin
          m0.bresp  = s.bresp;
          m0.bvalid = s.bvalid;
        end
        if (s.bvalid && wr_bready_sel_s) begin
          wr_state_nxt_s = W_IDLE;
          wr_last_nxt_s  = wr_grant_r;
        end else begin
          wr_state_nxt_s = W_RESP;
        end
      end
      default: begin
        wr_state_nxt_s = W_IDLE;
        aw_done_nxt_s  = 1'b0;
        w_done_nxt_s   = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_axi_lite_arb2.sv
// Directed bench for axi_lite_arb2: a table of read scenarios (single and
// contending masters) plus hand-written write, concurrency and reset sequences.
module tb_axi_lite_arb2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  int   aw_base, w_base;

  localparam logic [63:0] A0 = 64'h0000_0000_0000_1000;
  localparam logic [63:0] A1 = 64'h0000_0000_2000_0040;

  axi_lite_arb2_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) m0_bus ();
  axi_lite_arb2_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) m1_bus ();
  axi_lite_arb2_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) s_bus ();

  axi_lite_arb2 #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_bus),
    .m1  (m1_bus),
    .s   (s_bus)
  );

  always #5 clk = ~clk;

  // count slave-side handshakes
  always @(posedge clk) begin
    if (s_bus.awvalid && s_bus.awready) aw_cnt <= aw_cnt + 1;
    if (s_bus.wvalid && s_bus.wready)   w_cnt  <= w_cnt + 1;
    if (s_bus.arvalid && s_bus.arready) ar_cnt <= ar_cnt + 1;
  end

  typedef struct {
    logic        v0;
    logic        v1;
    int          ar_delay;
    logic [63:0] rdata;
    logic        exp_first;
  } rd_vec_t;

  rd_vec_t rv [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_bus.awaddr = '0; m0_bus.awvalid = 1'b0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
    m0_bus.wvalid = 1'b0; m0_bus.bready = 1'b0; m0_bus.araddr = '0; m0_bus.arvalid = 1'b0;
    m0_bus.rready = 1'b0;
    m1_bus.awaddr = '0; m1_bus.awvalid = 1'b0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
    m1_bus.wvalid = 1'b0; m1_bus.bready = 1'b0; m1_bus.araddr = '0; m1_bus.arvalid = 1'b0;
    m1_bus.rready = 1'b0;
    s_bus.awready = 1'b0; s_bus.wready = 1'b0; s_bus.bresp = 2'b00; s_bus.bvalid = 1'b0;
    s_bus.arready = 1'b0; s_bus.rdata = '0; s_bus.rresp = 2'b00; s_bus.rvalid = 1'b0;
  endtask

  function automatic logic [15:0] all_vr();
    return {m0_bus.awready, m0_bus.wready, m0_bus.bvalid, m0_bus.arready, m0_bus.rvalid,
            m1_bus.awready, m1_bus.wready, m1_bus.bvalid, m1_bus.arready, m1_bus.rvalid,
            s_bus.awvalid, s_bus.wvalid, s_bus.bready, s_bus.arvalid, s_bus.rready, 1'b0};
  endfunction

  // Serve every requester of one table row; the first grant must be exp_first.
  task automatic run_read(input rd_vec_t v);
    logic        pend0, pend1, cur;
    logic [63:0] d;
    pend0 = v.v0;
    pend1 = v.v1;
    @(negedge clk);
    m0_bus.arvalid = v.v0; m0_bus.araddr = A0;
    m1_bus.arvalid = v.v1; m1_bus.araddr = A1;
    s_bus.arready = 1'b0;
    #1 chk("rd_idle_no_ar", s_bus.arvalid, 1'b0);
    for (int k = 0; k < 2; k++) begin
      if (pend0 || pend1) begin
        cur = (k == 0) ? v.exp_first : ~v.exp_first;
        @(negedge clk);
        chk("rd_ar_valid", s_bus.arvalid, 1'b1);
        chk("rd_ar_addr", s_bus.araddr, cur ? A1 : A0);
        for (int j = 0; j < v.ar_delay; j++) begin
          @(negedge clk);
          chk("rd_ar_hold", s_bus.arvalid, 1'b1);
        end
        s_bus.arready = 1'b1;
        #1 chk("rd_arready_own", cur ? m1_bus.arready : m0_bus.arready, 1'b1);
        chk("rd_arready_other", cur ? m0_bus.arready : m1_bus.arready, 1'b0);
        @(negedge clk);
        s_bus.arready = 1'b0;
        if (cur) begin m1_bus.arvalid = 1'b0; pend1 = 1'b0; end
        else begin m0_bus.arvalid = 1'b0; pend0 = 1'b0; end
        d = (k == 0) ? v.rdata : ~v.rdata;
        s_bus.rdata = d; s_bus.rresp = 2'b00; s_bus.rvalid = 1'b1;
        m0_bus.rready = 1'b1; m1_bus.rready = 1'b1;
        #1 chk("rd_no_ar_in_data", s_bus.arvalid, 1'b0);
        chk("rd_rvalid_own", cur ? m1_bus.rvalid : m0_bus.rvalid, 1'b1);
        chk("rd_rdata_own", cur ? m1_bus.rdata : m0_bus.rdata, d);
        chk("rd_rvalid_other", cur ? m0_bus.rvalid : m1_bus.rvalid, 1'b0);
        chk("rd_rready_fwd", s_bus.rready, 1'b1);
        @(negedge clk);
        s_bus.rvalid = 1'b0; m0_bus.rready = 1'b0; m1_bus.rready = 1'b0;
        #1 chk("rd_back_idle", s_bus.arvalid, 1'b0);
      end
    end
  endtask

  initial begin
    rv[0] = '{v0: 1'b1, v1: 1'b0, ar_delay: 2, rdata: 64'hDEAD_BEEF_0000_0013, exp_first: 1'b0};
    rv[1] = '{v0: 1'b1, v1: 1'b1, ar_delay: 0, rdata: 64'h0000_0000_0000_0A01, exp_first: 1'b1};
    rv[2] = '{v0: 1'b1, v1: 1'b1, ar_delay: 1, rdata: 64'h0000_0000_0000_0A02, exp_first: 1'b1};
    rv[3] = '{v0: 1'b0, v1: 1'b1, ar_delay: 0, rdata: 64'h5555_0000_AAAA_0003, exp_first: 1'b1};
    rv[4] = '{v0: 1'b1, v1: 1'b1, ar_delay: 0, rdata: 64'h0000_0000_0000_0A04, exp_first: 1'b0};
    rv[5] = '{v0: 1'b1, v1: 1'b1, ar_delay: 3, rdata: 64'h0000_0000_0000_0A05, exp_first: 1'b0};

    // reset: every valid/ready output low even with slave and masters active
    clear_inputs();
    s_bus.arready = 1'b1; s_bus.awready = 1'b1; s_bus.wready = 1'b1;
    s_bus.rvalid = 1'b1; s_bus.bvalid = 1'b1;
    m0_bus.rready = 1'b1; m0_bus.bready = 1'b1; m1_bus.rready = 1'b1; m1_bus.bready = 1'b1;
    m0_bus.arvalid = 1'b1; m1_bus.awvalid = 1'b1;
    #1 chk("reset_outputs_zero", all_vr(), 16'h0000);
    repeat (2) @(negedge clk);
    chk("reset_outputs_held", all_vr(), 16'h0000);
    clear_inputs();
    rst = 1'b0;

    // m1 write: AW first, W three cycles later, strb 0x0F
    @(negedge clk);
    aw_base = aw_cnt; w_base = w_cnt;
    m1_bus.awvalid = 1'b1; m1_bus.awaddr = 64'h0000_0000_8000_0000;
    s_bus.awready = 1'b1; s_bus.wready = 1'b1;
    #1 chk("wr_idle_no_aw", s_bus.awvalid, 1'b0);
    @(negedge clk);
    chk("wr_aw_fwd", s_bus.awvalid, 1'b1);
    chk("wr_aw_addr", s_bus.awaddr, 64'h0000_0000_8000_0000);
    chk("wr_awready_m1", m1_bus.awready, 1'b1);
    chk("wr_awready_m0", m0_bus.awready, 1'b0);
    chk("wr_w_not_yet", s_bus.wvalid, 1'b0);
    // awvalid deliberately held: the forwarded copy must stay masked
    repeat (2) begin
      @(negedge clk);
      chk("wr_aw_masked", s_bus.awvalid, 1'b0);
    end
    @(negedge clk);
    m1_bus.wvalid = 1'b1; m1_bus.wdata = 64'h0123_4567_89AB_CDEF; m1_bus.wstrb = 8'h0F;
    #1 chk("wr_w_fwd", s_bus.wvalid, 1'b1);
    chk("wr_wstrb", s_bus.wstrb, 8'h0F);
    chk("wr_wdata", s_bus.wdata, 64'h0123_4567_89AB_CDEF);
    chk("wr_wready_m1", m1_bus.wready, 1'b1);
    chk("wr_wready_m0", m0_bus.wready, 1'b0);
    @(negedge clk);
    m1_bus.awvalid = 1'b0; m1_bus.wvalid = 1'b0;
    s_bus.bvalid = 1'b1; s_bus.bresp = 2'b00; m0_bus.bready = 1'b1; m1_bus.bready = 1'b1;
    #1 chk("wr_resp_no_w", s_bus.wvalid, 1'b0);
    chk("wr_bvalid_m1", m1_bus.bvalid, 1'b1);
    chk("wr_bresp_m1", m1_bus.bresp, 2'b00);
    chk("wr_bvalid_m0", m0_bus.bvalid, 1'b0);
    chk("wr_bready_fwd", s_bus.bready, 1'b1);
    @(negedge clk);
    clear_inputs();
    chk("wr_aw_count", aw_cnt - aw_base, 1);
    chk("wr_w_count", w_cnt - w_base, 1);

    // B stalled for 5 cycles while m0 waits with a new write
    @(negedge clk);
    m1_bus.awvalid = 1'b1; m1_bus.awaddr = 64'h0000_0000_8000_0100;
    m1_bus.wvalid = 1'b1; m1_bus.wdata = 64'h0000_0000_0000_00AA; m1_bus.wstrb = 8'hFF;
    s_bus.awready = 1'b1; s_bus.wready = 1'b1;
    @(negedge clk);
    chk("bst_aw_w_same", {s_bus.awvalid, s_bus.wvalid}, 2'b11);
    @(negedge clk);
    m1_bus.awvalid = 1'b0; m1_bus.wvalid = 1'b0;
    m0_bus.awvalid = 1'b1; m0_bus.awaddr = 64'h0000_0000_0000_3000;
    m0_bus.wvalid = 1'b1; m0_bus.wdata = 64'h0000_0000_0000_00BB; m0_bus.wstrb = 8'hF0;
    s_bus.bvalid = 1'b1; s_bus.bresp = 2'b10; m1_bus.bready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1 chk("bst_bvalid_m1", m1_bus.bvalid, 1'b1);
      chk("bst_bresp_m1", m1_bus.bresp, 2'b10);
      chk("bst_no_aw", s_bus.awvalid, 1'b0);
      chk("bst_awready_m0", m0_bus.awready, 1'b0);
      @(negedge clk);
    end
    m1_bus.bready = 1'b1;
    #1 chk("bst_bready_fwd", s_bus.bready, 1'b1);
    @(negedge clk);
    s_bus.bvalid = 1'b0; m1_bus.bready = 1'b0;
    #1 chk("bst_idle_no_aw", s_bus.awvalid, 1'b0);
    @(negedge clk);
    chk("bst_m0_aw_addr", s_bus.awaddr, 64'h0000_0000_0000_3000);
    chk("bst_m0_awready", {m0_bus.awready, m1_bus.awready}, 2'b10);
    chk("bst_m0_wstrb", s_bus.wstrb, 8'hF0);
    @(negedge clk);
    m0_bus.awvalid = 1'b0; m0_bus.wvalid = 1'b0;
    s_bus.bvalid = 1'b1; s_bus.bresp = 2'b00; m0_bus.bready = 1'b1; m1_bus.bready = 1'b1;
    #1 chk("bst_b_to_m0", {m0_bus.bvalid, m1_bus.bvalid}, 2'b10);
    @(negedge clk);
    clear_inputs();

    // read table: single requests and round-robin contention
    for (int i = 0; i < 6; i++) run_read(rv[i]);

    // m0 read concurrent with m1 write
    @(negedge clk);
    m0_bus.arvalid = 1'b1; m0_bus.araddr = A0;
    m1_bus.awvalid = 1'b1; m1_bus.awaddr = 64'h0000_0000_8000_0010;
    m1_bus.wvalid = 1'b1; m1_bus.wdata = 64'h0000_0000_0000_CAFE; m1_bus.wstrb = 8'hFF;
    s_bus.arready = 1'b1; s_bus.awready = 1'b1; s_bus.wready = 1'b1;
    @(negedge clk);
    chk("cc_fwd_valids", {s_bus.arvalid, s_bus.awvalid, s_bus.wvalid}, 3'b111);
    chk("cc_araddr", s_bus.araddr, A0);
    chk("cc_awaddr", s_bus.awaddr, 64'h0000_0000_8000_0010);
    chk("cc_readies", {m0_bus.arready, m1_bus.arready, m0_bus.awready, m1_bus.awready}, 4'b1001);
    @(negedge clk);
    clear_inputs();
    s_bus.rvalid = 1'b1; s_bus.rdata = 64'h1111_2222_3333_4444; s_bus.bvalid = 1'b1;
    s_bus.bresp = 2'b01;
    m0_bus.rready = 1'b1; m1_bus.rready = 1'b1; m0_bus.bready = 1'b1; m1_bus.bready = 1'b1;
    #1 chk("cc_r_route", {m0_bus.rvalid, m1_bus.rvalid}, 2'b10);
    chk("cc_rdata_m0", m0_bus.rdata, 64'h1111_2222_3333_4444);
    chk("cc_b_route", {m0_bus.bvalid, m1_bus.bvalid}, 2'b01);
    chk("cc_bresp_m1", m1_bus.bresp, 2'b01);
    @(negedge clk);
    clear_inputs();
    #1 chk("cc_both_idle", {s_bus.arvalid, s_bus.awvalid}, 2'b00);

    // reset in R_DATA with rvalid pending, then a fresh m1 read
    @(negedge clk);
    m0_bus.arvalid = 1'b1; m0_bus.araddr = A0; s_bus.arready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m0_bus.arvalid = 1'b0; s_bus.arready = 1'b0;
    s_bus.rvalid = 1'b1; s_bus.rdata = 64'h0000_0000_0000_0BAD; m0_bus.rready = 1'b1;
    #1 chk("rst_pre_rvalid", m0_bus.rvalid, 1'b1);
    rst = 1'b1;
    #1 chk("rst_outputs_zero", all_vr(), 16'h0000);
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    m1_bus.arvalid = 1'b1; m1_bus.araddr = A1;
    #1 chk("rst_idle_no_ar", s_bus.arvalid, 1'b0);
    @(negedge clk);
    chk("rst_m1_granted", s_bus.arvalid, 1'b1);
    chk("rst_m1_addr", s_bus.araddr, A1);
    s_bus.arready = 1'b1;
    #1 chk("rst_m1_arready", {m0_bus.arready, m1_bus.arready}, 2'b01);
    @(negedge clk);
    m1_bus.arvalid = 1'b0; s_bus.arready = 1'b0;
    s_bus.rvalid = 1'b1; s_bus.rdata = 64'h0000_0000_0000_600D; m1_bus.rready = 1'b1;
    #1 chk("rst_m1_rdata", m1_bus.rdata, 64'h0000_0000_0000_600D);
    chk("rst_r_route", {m0_bus.rvalid, m1_bus.rvalid}, 2'b01);
    @(negedge clk);
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
